// File: rtl/booth_multiplier_pkg.sv
// Shared constants for the radix-2 Booth multiplier: state encoding,
// default operand width and Booth-decode pairs.
package booth_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // {Q[0], q_m1} pairs that select an add or subtract of the multiplicand.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_multiplier_twos_negate.sv
// Combinational two's-complement negation (invert plus one) used to form
// the Booth subtract operand from the sign-extended multiplicand.
module twos_negate #(
  parameter int W = 33
) (
  input  logic [W-1:0] value_i,
  output logic [W-1:0] neg_o
);

  assign neg_o = ~value_i + W'(1);

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, one iteration per clock, with a
// start/busy/done handshake. Define MUL_OVF_EN to add the registered ovf output.
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef MUL_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       nm;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef MUL_OVF_EN
  logic                 ovf_q, ovf_d;
  logic [WIDTH:0]       prod_top;
`endif

  twos_negate #(.W(WIDTH + 1)) u_negate (
    .value_i (m_q),
    .neg_o   (nm)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum       = a_q;
`ifdef MUL_OVF_EN
    ovf_d     = ovf_q;
    prod_top  = '0;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          a_d     = '0;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cnt_q == '0) begin
          // Iterations are finished; the low WIDTH bits of A over Q form the product.
          state_d   = ST_DONE;
          product_d = {a_q[WIDTH-1:0], q_q};
`ifdef MUL_OVF_EN
          prod_top  = product_d[2*WIDTH-1:WIDTH-1];
          ovf_d     = !((&prod_top) || !(|prod_top));
`endif
        end else begin
          unique case ({q_q[0], qm1_q})
            BOOTH_ADD: sum = a_q + m_q;
            BOOTH_SUB: sum = a_q + nm;
            default:   sum = a_q;
          endcase
          // Arithmetic right shift of {A, Q, q_m1}, sign of A replicated.
          a_d   = {sum[WIDTH], sum[WIDTH:1]};
          q_d   = {sum[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MUL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MUL_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;
`ifdef MUL_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule
